control_clave: RTL and testbench
================================

# control_clave

Code-entry controller sitting directly downstream of the keypad driver. Consumes the 5-bit key code and its toggle-per-press strobe, collects `N_DIG` decimal digits, and checks them against a stored code on ENTER. Also supports reprogramming the code while open, and enforces a timed lockout after repeated failures. Outputs drive the 7-segment display stage (digit buffer) and the lock actuator/LEDs.

## Interface
- `N_DIG`, 4: digits per code.
- `CLAVE_INI`, 16'h1234: code after reset, `4*N_DIG` bits, BCD, first-entered digit in MS nibble.
- `MAX_FALLOS`, 3: consecutive failed ENTERs that trigger lockout.
- `T_BLOQ`, 3000: lockout length in clk cycles (30 s at 100 Hz).

- `clk`  in  1  system clock, 100 Hz keypad clock domain.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `digito`  in  5  key code: 0–9 digits, A–D, E = BORRAR, F = ENTER, 16/17 = no key/invalid.
- `cambio_digito`  in  1  toggles once per accepted key press; `digito` is valid when it toggles.
- `display`  out  4*N_DIG  entered digits, newest in LS nibble, empty positions = 4'hF (blank).
- `cant`  out  $clog2(N_DIG+1)  number of digits currently buffered.
- `abierto`  out  1  level, high in state ABIERTO.
- `modo_prog`  out  1  level, high in state PROG.
- `bloqueado`  out  1  level, high in state BLOQUEO.
- `ok`  out  1  one-cycle pulse: correct code or new code stored.
- `error`  out  1  one-cycle pulse: wrong/incomplete code.

## Operation
- Event detect: register `cambio_previo`; `evento = cambio_digito ^ cambio_previo`. During reset `cambio_previo <= cambio_digito` so no spurious event. Events with `digito` ≥ 16 are ignored.
- Digit (0–9) in ENTRADA/PROG: if `cant < N_DIG`, shift `display` left 4, insert digit in LS nibble, `cant++`; if full, ignored.
- States: ENTRADA (reset), ABIERTO, PROG, BLOQUEO.
- ENTRADA: E clears buffer. F: if `cant == N_DIG` and `display == clave` → `ok`, `fallos <= 0`, go ABIERTO; otherwise → `error`, `fallos++`; if new `fallos == MAX_FALLOS` → BLOQUEO, timer loaded with `T_BLOQ`. Buffer cleared after any F. A–D ignored.
- ABIERTO: digits ignored. A → PROG (buffer cleared). E or F → ENTRADA.
- PROG: F with `cant == N_DIG` → `clave <= display`, `ok`, go ENTRADA; F with `cant < N_DIG` → `error`, stay PROG. E → ENTRADA, code unchanged. Buffer cleared on every exit and on every F.
- BLOQUEO: all events ignored (but `cambio_previo` still tracks). Timer decrements each cycle; on reaching 0 → ENTRADA, `fallos <= 0`.
- `clave` is not affected by lockout; reset restores `CLAVE_INI`.

## Timing
- Reset values: `display` all 4'hF, `cant` 0, `abierto`/`modo_prog`/`bloqueado`/`ok`/`error` 0, state ENTRADA, `fallos` 0, `clave` = `CLAVE_INI`.
- All outputs registered. Toggle sampled at edge t → action and updated outputs visible after edge t; `ok`/`error` high for exactly that one cycle.
- Back-to-back events in consecutive cycles are each processed; no event is lost.
- BLOQUEO lasts exactly `T_BLOQ` cycles: `bloqueado` high from the edge of the failing F through `T_BLOQ` cycles, ENTRADA on the following edge.
- `rst_n` low at any edge, including mid-lockout or mid-programming, restores all reset values on that edge.
- Counters saturate: `cant` never exceeds `N_DIG`; `fallos` never exceeds `MAX_FALLOS`.

## Structure
- Shared package `clave_pkg`: state enum (ENTRADA, ABIERTO, PROG, BLOQUEO), key constants TECLA_BORRAR = 5'hE, TECLA_ENTER = 5'hF, TECLA_PROG = 5'hA, TECLA_NINGUNA = 5'd16, blank nibble 4'hF.
- One sub-module `buffer_digitos`: shift register + `cant`, with push/clear inputs and `lleno` flag. FSM, event detect, `fallos` and timer live in the top.

## Test plan
- Reset, enter 1,2,3,4, F → `display` 16'hFFFF after F, `ok` 1 cycle, `abierto` = 1.
- Enter 1,2,3,4,5 → fifth ignored, `cant` = 4, `display` = 16'h1234; E → 16'hFFFF, `cant` 0.
- Three wrong codes (9,9,9,9,F) → `error` ×3, `bloqueado` high exactly `T_BLOQ` (use 10) cycles, keys ignored, then ENTRADA with `fallos` 0.
- Open, A, 5,6,7,8, F → `ok`, ENTRADA; 1,2,3,4,F → `error`; 5,6,7,8,F → `ok`, `abierto`.
- PROG with 2 digits then F → `error`, stays PROG; E → ENTRADA, old code still valid.
- `rst_n` low during BLOQUEO and during PROG → all reset values next edge; no event fired from `cambio_digito` level at reset release.

Source files
------------

// File: rtl/clave_pkg.sv
// Shared types and key constants for the code-entry controller.
// Keypad codes match the upstream keypad driver encoding.
package clave_pkg;

  typedef enum logic [1:0] {
    ENTRADA = 2'd0,
    ABIERTO = 2'd1,
    PROG    = 2'd2,
    BLOQUEO = 2'd3
  } estado_t;

  localparam logic [4:0] TECLA_PROG    = 5'hA;
  localparam logic [4:0] TECLA_BORRAR  = 5'hE;
  localparam logic [4:0] TECLA_ENTER   = 5'hF;
  localparam logic [4:0] TECLA_NINGUNA = 5'd16;
  localparam logic [3:0] NIBBLE_BLANCO = 4'hF;

  function automatic logic es_digito(input logic [4:0] tecla);
    return (tecla < 5'd10);
  endfunction

endpackage

// File: rtl/buffer_digitos.sv
// Digit shift buffer feeding the 7-segment stage: newest digit enters the
// LS nibble, unused positions read as blank.
module buffer_digitos
  import clave_pkg::*;
#(
  parameter int N_DIG = 4,
  parameter int CW    = $clog2(N_DIG + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 clear,
  input  logic [3:0]           dato,
  output logic [4*N_DIG-1:0]   display,
  output logic [CW-1:0]        cant,
  output logic                 lleno
);

  assign lleno = (cant == CW'(N_DIG));

  // Buffer and fill count; clear wins over push, a push into a full buffer is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display <= {N_DIG{NIBBLE_BLANCO}};
      cant    <= '0;
    end else if (clear) begin
      display <= {N_DIG{NIBBLE_BLANCO}};
      cant    <= '0;
    end else if (push && !lleno) begin
      display <= {display[4*N_DIG-5:0], dato};
      cant    <= cant + CW'(1);
    end
  end

endmodule

// File: rtl/control_clave.sv
// Code-entry controller: collects keypad digits, checks/reprograms the stored
// code and enforces a timed lockout after repeated failures.
module control_clave
  import clave_pkg::*;
#(
  parameter int                 N_DIG      = 4,
  parameter logic [4*N_DIG-1:0] CLAVE_INI  = 16'h1234,
  parameter int                 MAX_FALLOS = 3,
  parameter int                 T_BLOQ     = 3000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [4:0]                   digito,
  input  logic                         cambio_digito,
  output logic [4*N_DIG-1:0]           display,
  output logic [$clog2(N_DIG+1)-1:0]   cant,
  output logic                         abierto,
  output logic                         modo_prog,
  output logic                         bloqueado,
  output logic                         ok,
  output logic                         error
);

  localparam int CW = $clog2(N_DIG + 1);
  localparam int FW = $clog2(MAX_FALLOS + 1);
  localparam int TW = $clog2(T_BLOQ + 1);

  estado_t             estado_r, estado_s;
  logic                cambio_previo_r;
  logic [FW-1:0]       fallos_r, fallos_s;
  logic [TW-1:0]       timer_r, timer_s;
  logic [4*N_DIG-1:0]  clave_r, clave_s;
  logic                ok_s, error_s, push_s, clear_s, lleno_s, evento_s;

  assign evento_s = (cambio_digito ^ cambio_previo_r) && (digito < TECLA_NINGUNA);

  buffer_digitos #(.N_DIG(N_DIG), .CW(CW)) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .clear   (clear_s),
    .dato    (digito[3:0]),
    .display (display),
    .cant    (cant),
    .lleno   (lleno_s)
  );

  // Next-state and action decode for every key event and the lockout timer.
  always_comb begin
    estado_s = estado_r;
    fallos_s = fallos_r;
    timer_s  = timer_r;
    clave_s  = clave_r;
    ok_s     = 1'b0;
    error_s  = 1'b0;
    push_s   = 1'b0;
    clear_s  = 1'b0;
    case (estado_r)
      ENTRADA: begin
        if (evento_s) begin
          if (es_digito(digito)) begin
            push_s = 1'b1;
          end else if (digito == TECLA_BORRAR) begin
            clear_s = 1'b1;
          end else if (digito == TECLA_ENTER) begin
            clear_s = 1'b1;
            if (lleno_s && (display == clave_r)) begin
              ok_s     = 1'b1;
              fallos_s = '0;
              estado_s = ABIERTO;
            end else begin
              error_s = 1'b1;
              if (fallos_r < FW'(MAX_FALLOS)) begin
                fallos_s = fallos_r + FW'(1);
              end else begin
                fallos_s = fallos_r;
              end
              if (fallos_s == FW'(MAX_FALLOS)) begin
                estado_s = BLOQUEO;
                timer_s  = TW'(T_BLOQ);
              end else begin
                estado_s = ENTRADA;
              end
            end
          end else begin
            push_s = 1'b0;
          end
        end else begin
          push_s = 1'b0;
        end
      end
      ABIERTO: begin
        if (evento_s && (digito == TECLA_PROG)) begin
          clear_s  = 1'b1;
          estado_s = PROG;
        end else if (evento_s && ((digito == TECLA_BORRAR) || (digito == TECLA_ENTER))) begin
          clear_s  = 1'b1;
          estado_s = ENTRADA;
        end else begin
          estado_s = ABIERTO;
        end
      end
      PROG: begin
        if (evento_s && es_digito(digito)) begin
          push_s = 1'b1;
        end else if (evento_s && (digito == TECLA_ENTER)) begin
          clear_s = 1'b1;
          if (lleno_s) begin
            clave_s  = display;
            ok_s     = 1'b1;
            estado_s = ENTRADA;
          end else begin
            error_s = 1'b1;
          end
        end else if (evento_s && (digito == TECLA_BORRAR)) begin
          clear_s  = 1'b1;
          estado_s = ENTRADA;
        end else begin
          estado_s = PROG;
        end
      end
      BLOQUEO: begin
        // Timer was loaded with T_BLOQ on the failing edge, so leaving at 1 gives T_BLOQ cycles.
        timer_s = timer_r - TW'(1);
        if (timer_r == TW'(1)) begin
          estado_s = ENTRADA;
          fallos_s = '0;
        end else begin
          estado_s = BLOQUEO;
        end
      end
      default: begin
        estado_s = ENTRADA;
      end
    endcase
  end

  // State, counters, stored code and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cambio_previo_r <= cambio_digito;
      estado_r        <= ENTRADA;
      fallos_r        <= '0;
      timer_r         <= '0;
      clave_r         <= CLAVE_INI;
      ok              <= 1'b0;
      error           <= 1'b0;
      abierto         <= 1'b0;
      modo_prog       <= 1'b0;
      bloqueado       <= 1'b0;
    end else begin
      cambio_previo_r <= cambio_digito;
      estado_r        <= estado_s;
      fallos_r        <= fallos_s;
      timer_r         <= timer_s;
      clave_r         <= clave_s;
      ok              <= ok_s;
      error           <= error_s;
      abierto         <= (estado_s == ABIERTO);
      modo_prog       <= (estado_s == PROG);
      bloqueado       <= (estado_s == BLOQUEO);
    end
  end

endmodule

// File: tb/tb_control_clave.sv
// Self-checking bench for control_clave: directed scenarios plus random key
// traffic, compared every cycle against a queue-based behavioural model.
module tb_control_clave;

  localparam int N     = 4;
  localparam int MAXF  = 3;
  localparam int TB    = 10;

  logic            clk;
  logic            rst_n;
  logic [4:0]      digito;
  logic            cambio_digito;
  logic [4*N-1:0]  display;
  logic [2:0]      cant;
  logic            abierto, modo_prog, bloqueado, ok, error;

  control_clave #(.N_DIG(N), .CLAVE_INI(16'h1234), .MAX_FALLOS(MAXF), .T_BLOQ(TB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .digito        (digito),
    .cambio_digito (cambio_digito),
    .display       (display),
    .cant          (cant),
    .abierto       (abierto),
    .modo_prog     (modo_prog),
    .bloqueado     (bloqueado),
    .ok            (ok),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 entry, 1 open, 2 programming, 3 locked out.
  int  mode;
  int  q[$];
  int  code[$];
  int  fails;
  int  lock_cnt;
  bit  m_ok, m_err;
  int  n_vec, n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4*N-1:0] exp_display();
    logic [4*N-1:0] v;
    v = '1;
    foreach (q[i]) v = {v[4*N-5:0], 4'(q[i])};
    return v;
  endfunction

  task automatic model_step(input bit rst, input bit evt, input int d);
    bit match;
    m_ok  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      mode = 0; q.delete(); code = '{1, 2, 3, 4}; fails = 0; lock_cnt = 0;
    end else if (mode == 3) begin
      lock_cnt--;
      if (lock_cnt == 0) begin mode = 0; fails = 0; end
    end else if (evt && d < 16) begin
      case (mode)
        0: begin
          if (d < 10) begin
            if (q.size() < N) q.push_back(d);
          end else if (d == 14) begin
            q.delete();
          end else if (d == 15) begin
            match = (q.size() == N);
            if (match) foreach (q[i]) if (q[i] != code[i]) match = 1'b0;
            q.delete();
            if (match) begin m_ok = 1'b1; fails = 0; mode = 1; end
            else begin
              m_err = 1'b1; fails++;
              if (fails == MAXF) begin mode = 3; lock_cnt = TB; end
            end
          end
        end
        1: begin
          if (d == 10) begin mode = 2; q.delete(); end
          else if (d == 14 || d == 15) begin mode = 0; q.delete(); end
        end
        2: begin
          if (d < 10) begin
            if (q.size() < N) q.push_back(d);
          end else if (d == 15) begin
            if (q.size() == N) begin code = q; m_ok = 1'b1; mode = 0; end
            else m_err = 1'b1;
            q.delete();
          end else if (d == 14) begin
            mode = 0; q.delete();
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("display",   32'(display),   32'(exp_display()));
    check_eq("cant",      32'(cant),      32'(q.size()));
    check_eq("abierto",   32'(abierto),   32'(mode == 1));
    check_eq("modo_prog", 32'(modo_prog), 32'(mode == 2));
    check_eq("bloqueado", 32'(bloqueado), 32'(mode == 3));
    check_eq("ok",        32'(ok),        32'(m_ok));
    check_eq("error",     32'(error),     32'(m_err));
  endtask

  // One clock: drive at negedge, step model at posedge, sample 1 time unit later.
  task automatic cycle(input bit rst, input bit evt, input int d);
    @(negedge clk);
    rst_n = !rst;
    if (evt) begin
      digito        = 5'(d);
      cambio_digito = ~cambio_digito;
    end else begin
      digito = 5'($urandom_range(0, 31));
    end
    @(posedge clk);
    model_step(rst, evt, d);
    #1;
    compare_all();
  endtask

  task automatic press(input int d);
    cycle(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int e);
    press(a); press(b); press(c); press(e); press(15);
  endtask

  initial begin
    int r, d;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; digito = 5'd16; cambio_digito = 1'b0;
    mode = 0; fails = 0; lock_cnt = 0; code = '{1, 2, 3, 4};

    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 3);
    idle(2);

    enter4(1, 2, 3, 4);
    idle(2);
    press(14);
    press(1); press(2); press(3); press(4); press(5);
    press(14);

    repeat (3) enter4(9, 9, 9, 9);
    repeat (4) press(1);
    press(15);
    idle(8);
    enter4(9, 9, 9, 9);
    enter4(1, 2, 3, 4);

    press(10); enter4(5, 6, 7, 8);
    enter4(1, 2, 3, 4);
    enter4(5, 6, 7, 8);
    press(10); press(1); press(2); press(15);
    press(14);
    enter4(5, 6, 7, 8);
    press(14);

    enter4(5, 6, 7, 8);
    press(10); press(1);
    cycle(1'b1, 1'b1, 2);
    idle(2);
    repeat (3) enter4(7, 7, 7, 7);
    idle(3);
    cycle(1'b1, 1'b1, 4);
    idle(1);
    enter4(1, 2, 3, 4);
    press(14);

    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        cycle(1'b1, $urandom_range(0, 1) == 1, 1);
      end else if (r < 20) begin
        idle($urandom_range(1, 3));
      end else if (r < 60) begin
        d = (q.size() < N) ? code[q.size()] : 15;
        press(d);
      end else begin
        press($urandom_range(0, 17));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
